// File: rtl/fcp6_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fcp6_pkg                                                             |
// | Shared FCP6 bus codes and master state encoding.                     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package fcp6_pkg;

  localparam logic [1:0] CTRL_START = 2'b01;
  localparam logic [1:0] CTRL_DATA  = 2'b00;
  localparam logic [1:0] CTRL_RESP  = 2'b10;
  localparam logic [1:0] CTRL_STOP  = 2'b11;

  localparam logic ACK_OK   = 1'b0;
  localparam logic ACK_NACK = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_START   = 4'd1,
    ST_HEADER  = 4'd2,
    ST_HDR_ACK = 4'd3,
    ST_WR_DATA = 4'd4,
    ST_WR_ACK  = 4'd5,
    ST_RD_TURN = 4'd6,
    ST_RD_DATA = 4'd7,
    ST_RD_ACK  = 4'd8,
    ST_STOP    = 4'd9,
    ST_DONE    = 4'd10
  } master_state_t;

endpackage
`default_nettype wire

// File: rtl/fcp6_dibit_shift.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fcp6_dibit_shift                                                     |
// | 8-bit register: parallel load, shift out MSB dibit, shift in dibit.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fcp6_dibit_shift (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  input  logic       i_shift_out,
  input  logic       i_shift_in,
  input  logic [1:0] i_din,
  output logic [1:0] o_msb,
  output logic [7:0] o_q
);

  logic [7:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_load_val;
    end else if (i_shift_in) begin
      r_q <= {r_q[5:0], i_din};
    end else if (i_shift_out) begin
      r_q <= {r_q[5:0], 2'b00};
    end
  end

  assign o_msb = r_q[7:6];
  assign o_q   = r_q;

endmodule
`default_nettype wire

// File: rtl/fcp6_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fcp6_master                                                          |
// | FCP6 initiator: START, header, one-byte write or read, STOP.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fcp6_master
  import fcp6_pkg::*;
#(
  parameter int MAX_RETRY   = 3,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic       rw,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       err,
  inout  wire  [1:0] ctrl,
  inout  wire  [1:0] data,
  inout  wire        ack
);

  localparam int c_tmo_w   = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam int c_retry_w = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [c_tmo_w-1:0]   c_tmo_last  = c_tmo_w'(ACK_TIMEOUT - 1);
  localparam logic [c_retry_w-1:0] c_retry_max = c_retry_w'(MAX_RETRY);

  master_state_t        r_state;
  logic                 r_rw;
  logic [7:0]           r_wdata;
  logic [1:0]           r_dibit_cnt;
  logic [c_tmo_w-1:0]   r_tmo_cnt;
  logic [c_retry_w-1:0] r_retry_cnt;

  logic       r_ctrl_oe, r_data_oe, r_ack_oe;
  logic [1:0] r_ctrl_val, r_data_val;

  logic       w_ack_ok, w_ack_nack, w_tmo_hit, w_retry_left;
  logic       w_sh_load, w_sh_shift_out, w_sh_shift_in;
  logic [7:0] w_sh_load_val, w_sh_q;
  logic [1:0] w_sh_msb;
  logic       w_ctrl_oe, w_data_oe, w_ack_oe;
  logic [1:0] w_ctrl_val;

  // A floating or unknown ack matches neither code and only advances the timeout.
  assign w_ack_ok     = (ack == ACK_OK);
  assign w_ack_nack   = (ack == ACK_NACK);
  assign w_tmo_hit    = (r_tmo_cnt == c_tmo_last);
  assign w_retry_left = (r_retry_cnt != c_retry_max);

  fcp6_dibit_shift u_shift (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_sh_load),
    .i_load_val  (w_sh_load_val),
    .i_shift_out (w_sh_shift_out),
    .i_shift_in  (w_sh_shift_in),
    .i_din       (data),
    .o_msb       (w_sh_msb),
    .o_q         (w_sh_q)
  );

  always_comb begin
    w_sh_load      = 1'b0;
    w_sh_load_val  = r_wdata;
    w_sh_shift_out = 1'b0;
    w_sh_shift_in  = 1'b0;
    w_ctrl_oe      = 1'b0;
    w_ctrl_val     = CTRL_DATA;
    w_data_oe      = 1'b0;
    w_ack_oe       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_sh_load     = start;
        w_sh_load_val = {addr, rw};
      end
      ST_START: begin
        w_ctrl_oe  = 1'b1;
        w_ctrl_val = CTRL_START;
      end
      ST_HEADER, ST_WR_DATA: begin
        w_sh_shift_out = 1'b1;
        w_ctrl_oe      = 1'b1;
        w_data_oe      = 1'b1;
      end
      ST_HDR_ACK: w_sh_load = w_ack_ok && r_rw;
      ST_WR_ACK:  w_sh_load = w_ack_nack && w_retry_left;
      ST_RD_DATA: w_sh_shift_in = 1'b1;
      ST_RD_ACK:  w_ack_oe = 1'b1;
      ST_STOP: begin
        w_ctrl_oe  = 1'b1;
        w_ctrl_val = CTRL_STOP;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_rw        <= 1'b0;
      r_wdata     <= '0;
      r_dibit_cnt <= '0;
      r_tmo_cnt   <= '0;
      r_retry_cnt <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      rdata       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_rw    <= rw;
            r_wdata <= wdata;
            err     <= 1'b0;
            busy    <= 1'b1;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          r_dibit_cnt <= '0;
          r_state     <= ST_HEADER;
        end
        ST_HEADER, ST_WR_DATA: begin
          if (r_dibit_cnt == 2'd3) begin
            r_tmo_cnt <= '0;
            r_state   <= (r_state == ST_HEADER) ? ST_HDR_ACK : ST_WR_ACK;
          end else begin
            r_dibit_cnt <= r_dibit_cnt + 2'd1;
          end
        end
        ST_HDR_ACK: begin
          if (w_ack_ok) begin
            r_dibit_cnt <= '0;
            r_retry_cnt <= '0;
            r_state     <= r_rw ? ST_WR_DATA : ST_RD_TURN;
          end else if (w_tmo_hit) begin
            err     <= 1'b1;
            r_state <= ST_STOP;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        ST_WR_ACK: begin
          if (w_ack_ok) begin
            r_state <= ST_STOP;
          end else if (w_ack_nack) begin
            if (w_retry_left) begin
              r_retry_cnt <= r_retry_cnt + 1'b1;
              r_dibit_cnt <= '0;
              r_state     <= ST_WR_DATA;
            end else begin
              err     <= 1'b1;
              r_state <= ST_STOP;
            end
          end else if (w_tmo_hit) begin
            err     <= 1'b1;
            r_state <= ST_STOP;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        ST_RD_TURN: begin
          if (r_dibit_cnt == 2'd1) begin
            r_dibit_cnt <= '0;
            r_state     <= ST_RD_DATA;
          end else begin
            r_dibit_cnt <= r_dibit_cnt + 2'd1;
          end
        end
        ST_RD_DATA: begin
          if (r_dibit_cnt == 2'd3) begin
            r_state <= ST_RD_ACK;
          end else begin
            r_dibit_cnt <= r_dibit_cnt + 2'd1;
          end
        end
        ST_RD_ACK: r_state <= ST_STOP;
        ST_STOP: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          if (!r_rw) begin
            rdata <= w_sh_q;
          end
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          done    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Bus drivers move half a cycle after the state so ownership changes never collide.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_ctrl_oe  <= 1'b0;
      r_ctrl_val <= CTRL_DATA;
      r_data_oe  <= 1'b0;
      r_data_val <= 2'b00;
      r_ack_oe   <= 1'b0;
    end else begin
      r_ctrl_oe  <= w_ctrl_oe;
      r_ctrl_val <= w_ctrl_val;
      r_data_oe  <= w_data_oe;
      r_data_val <= w_sh_msb;
      r_ack_oe   <= w_ack_oe;
    end
  end

  assign ctrl = r_ctrl_oe ? r_ctrl_val : 2'bzz;
  assign data = r_data_oe ? r_data_val : 2'bzz;
  assign ack  = r_ack_oe  ? ACK_OK     : 1'bz;

endmodule
`default_nettype wire

// File: tb/tb_fcp6_master.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fcp6_master                                                       |
// | Scoreboard bench for fcp6_master with a behavioural FCP6 responder.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_fcp6_master;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       start = 1'b0;
  logic       rw    = 1'b0;
  logic [6:0] addr  = '0;
  logic [7:0] wdata = '0;
  logic       busy, done, err;
  logic [7:0] rdata;
  wire  [1:0] ctrl;
  wire  [1:0] data;
  wire        ack;

  // Released lines read as 1 so that "released" is observable.
  pullup pu_c0 (ctrl[0]);
  pullup pu_c1 (ctrl[1]);
  pullup pu_d0 (data[0]);
  pullup pu_d1 (data[1]);
  pullup pu_a  (ack);

  logic       drv_bus_oe = 1'b0;
  logic [1:0] drv_data   = 2'b00;
  logic       drv_ack_oe = 1'b0;
  logic       drv_ack_v  = 1'b0;

  assign ctrl = drv_bus_oe ? 2'b10 : 2'bzz;
  assign data = drv_bus_oe ? drv_data : 2'bzz;
  assign ack  = drv_ack_oe ? drv_ack_v : 1'bz;

  fcp6_master #(.MAX_RETRY(3), .ACK_TIMEOUT(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .addr  (addr),
    .rw    (rw),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .rdata (rdata),
    .err   (err),
    .ctrl  (ctrl),
    .data  (data),
    .ack   (ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         err;
    bit         is_rd;
    logic [7:0] rdata;
    logic [7:0] hdr;
    logic [7:0] wbyte;
    int         bursts;
    int         lat;
    int         macks;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   t0       = 0;

  function automatic void check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic exp_t mk(input bit e, input bit rd, input logic [7:0] rb,
                              input logic [7:0] h, input logic [7:0] wb,
                              input int nb, input int lat, input int ma);
    exp_t x;
    x.err = e; x.is_rd = rd; x.rdata = rb; x.hdr = h; x.wbyte = wb;
    x.bursts = nb; x.lat = lat; x.macks = ma;
    return x;
  endfunction

  // Responder model configuration and observations.
  bit         cfg_hdr_ack = 1'b1;
  int         cfg_nacks   = 0;
  logic [7:0] cfg_rbyte   = '0;
  logic [7:0] seen_hdr    = '0;
  logic [7:0] seen_wbyte  = '0;
  int         bursts      = 0;
  int         bursts_base = 0;
  int         macks       = 0;
  int         macks_base  = 0;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_HACK, S_WDAT, S_WACK, S_RTURN, S_RDAT} rstate_t;
  rstate_t    rs = S_IDLE;
  int         rcnt = 0;
  logic [7:0] rsh = '0;
  logic       p_bus_oe = 1'b0, p_ack_oe = 1'b0, p_ack_v = 1'b0;
  logic [1:0] p_data = 2'b00;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Responder: samples on rising edges, plans drives applied on the next falling edge.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      rs = S_IDLE; p_bus_oe = 1'b0; p_ack_oe = 1'b0;
    end else begin
      if (!drv_ack_oe && ack == 1'b0) macks++;
      case (rs)
        S_IDLE: if (ctrl == 2'b01) begin rs = S_HDR; rcnt = 0; end
        S_HDR: begin
          if (ctrl != 2'b00) rs = S_IDLE;
          else begin
            rsh = {rsh[5:0], data}; rcnt++;
            if (rcnt == 4) begin
              seen_hdr = rsh;
              if (cfg_hdr_ack) begin p_ack_oe = 1'b1; p_ack_v = 1'b0; rs = S_HACK; end
              else rs = S_IDLE;
            end
          end
        end
        S_HACK: begin
          p_ack_oe = 1'b0; rcnt = 0;
          rs = rsh[0] ? S_WDAT : S_RTURN;
        end
        S_WDAT: begin
          if (ctrl != 2'b00) rs = S_IDLE;
          else begin
            rsh = {rsh[5:0], data}; rcnt++;
            if (rcnt == 4) begin
              seen_wbyte = rsh;
              p_ack_oe = 1'b1;
              p_ack_v = ((bursts - bursts_base) < cfg_nacks);
              bursts++;
              rs = S_WACK;
            end
          end
        end
        S_WACK: begin
          p_ack_oe = 1'b0; rcnt = 0;
          rs = p_ack_v ? S_WDAT : S_IDLE;
        end
        S_RTURN: begin
          rcnt++;
          if (rcnt == 2) begin
            p_bus_oe = 1'b1; p_data = cfg_rbyte[7:6];
            rsh = {cfg_rbyte[5:0], 2'b00}; rcnt = 0; rs = S_RDAT;
          end
        end
        S_RDAT: begin
          rcnt++;
          if (rcnt == 4) begin p_bus_oe = 1'b0; rs = S_IDLE; end
          else begin p_data = rsh[7:6]; rsh = {rsh[5:0], 2'b00}; end
        end
        default: rs = S_IDLE;
      endcase
    end
  end

  initial forever begin
    @(negedge clk);
    drv_bus_oe = rst ? 1'b0 : p_bus_oe;
    drv_data   = p_data;
    drv_ack_oe = rst ? 1'b0 : p_ack_oe;
    drv_ack_v  = p_ack_v;
  end

  // Monitor: every done pulse pops one expectation.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst && done) begin
      if (q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = q.pop_front();
        check("done_err", int'(err), int'(e.err));
        check("latency", cyc - t0, e.lat);
        check("header_on_bus", int'(seen_hdr), int'(e.hdr));
        check("data_bursts", bursts - bursts_base, e.bursts);
        if (e.bursts > 0) check("wdata_on_bus", int'(seen_wbyte), int'(e.wbyte));
        if (e.is_rd && !e.err) check("rdata", int'(rdata), int'(e.rdata));
        check("master_ack_cycles", macks - macks_base, e.macks);
        check("busy_at_done", int'(busy), 0);
      end
    end
  end

  task automatic run_txn(input logic r_w, input logic [6:0] a, input logic [7:0] wd,
                         input bit hack, input int nacks, input logic [7:0] rb,
                         input exp_t e, input bit pulse_busy, input bit hold_on_done);
    bit seen = 1'b0;
    cfg_hdr_ack = hack; cfg_nacks = nacks; cfg_rbyte = rb;
    @(negedge clk);
    bursts_base = bursts; macks_base = macks;
    addr = a; rw = r_w; wdata = wd; start = 1'b1;
    q.push_back(e);
    @(posedge clk); #1;
    t0 = cyc; start = 1'b0; addr = '0; wdata = '0; rw = ~r_w;
    check("busy_after_accept", int'(busy), 1);
    check("err_cleared_on_accept", int'(err), 0);
    if (pulse_busy) begin
      repeat (3) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      check("done_timeout", 0, 1);
      q.delete();
    end else if (hold_on_done) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("start_during_done_ignored", int'(busy), 0);
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk); #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_rdata", int'(rdata), 0);
    check("rst_ctrl_released", int'(ctrl), 3);
    check("rst_data_released", int'(data), 3);
    check("rst_ack_released", int'(ack), 1);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("idle_ctrl_released", int'(ctrl), 3);

    // Write 2A/C3, responder ACKs both phases.
    run_txn(1'b1, 7'h2A, 8'hC3, 1'b1, 0, 8'h00, mk(1'b0, 1'b0, 8'h00, 8'h55, 8'hC3, 1, 12, 0), 1'b0, 1'b0);
    // Read 10 returning 55, with start pulsed while busy and held at done.
    run_txn(1'b0, 7'h10, 8'h00, 1'b1, 0, 8'h55, mk(1'b0, 1'b1, 8'h55, 8'h20, 8'h00, 0, 14, 1), 1'b1, 1'b1);
    // Two NACKs then ACK.
    run_txn(1'b1, 7'h33, 8'hA5, 1'b1, 2, 8'h00, mk(1'b0, 1'b0, 8'h00, 8'h67, 8'hA5, 3, 22, 0), 1'b0, 1'b0);
    check("rdata_held_after_write", int'(rdata), 8'h55);
    // Persistent NACK: 1 + MAX_RETRY bursts then error.
    run_txn(1'b1, 7'h01, 8'h3C, 1'b1, 100, 8'h00, mk(1'b1, 1'b0, 8'h00, 8'h03, 8'h3C, 4, 27, 0), 1'b0, 1'b0);
    // No responder: header ACK timeout.
    run_txn(1'b0, 7'h7F, 8'h00, 1'b0, 0, 8'h00, mk(1'b1, 1'b1, 8'h00, 8'hFE, 8'h00, 0, 14, 0), 1'b0, 1'b0);

    // Reset in the middle of WR_DATA.
    cfg_hdr_ack = 1'b1; cfg_nacks = 0;
    @(negedge clk);
    addr = 7'h22; rw = 1'b1; wdata = 8'h00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    check("ctrl_driven_in_wr_data", int'(ctrl), 0);
    rst = 1'b1;
    #1;
    check("rst_mid_ctrl_released", int'(ctrl), 3);
    check("rst_mid_data_released", int'(data), 3);
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_done", int'(done), 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(posedge clk);

    // Normal write after the aborted one.
    run_txn(1'b1, 7'h55, 8'h0F, 1'b1, 0, 8'h00, mk(1'b0, 1'b0, 8'h00, 8'hAB, 8'h0F, 1, 12, 0), 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    check("scoreboard_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
